// File: rtl/reaction_pkg.sv
// Shared types and constants for the multi-round reaction-timer sequencer.
package reaction_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StTiming,
        StResult,
        StFoul,
        StSummary
    } state_t;

    localparam logic [15:0] DISP_IDLE  = 16'h0000;
    localparam logic [15:0] DISP_WAIT  = 16'hBBBB;
    localparam logic [15:0] DISP_FOUL  = 16'hFFFF;
    localparam logic [15:0] SCORE_FOUL = 16'h9999;
    localparam logic [15:0] T_TIMEOUT  = 16'h1000;

    localparam int unsigned WAIT_BASE_S = 2;

    // Random pre-go delay in ms ticks: (base + dly) seconds.
    function automatic logic [13:0] wait_ms(input logic [2:0] dly);
        return (14'(WAIT_BASE_S) + {11'b0, dly}) * 14'd1000;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every CLK_PER_MS clocks, held at zero while cleared.
module ms_tick_gen #(
    parameter int unsigned CLK_PER_MS = 100000
) (
    input  logic clk,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_MS - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (clear || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == LAST) && !clear;

endmodule

// File: rtl/reaction_round_seq.sv
// Multi-round reaction-timer session sequencer: drives the BCD ms counter, scores rounds,
// tracks the best time and produces the four display digits.
module reaction_round_seq
    import reaction_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = 4,
    parameter int unsigned CLK_PER_MS = 100000
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] rnd,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    output logic       count_start,
    output logic       count_clear,
    output logic       led,
    output logic [3:0] hex3,
    output logic [3:0] hex2,
    output logic [3:0] hex1,
    output logic [3:0] hex0,
    output logic [3:0] round_idx,
    output logic       session_done
);

    state_t      state_q, state_d;
    logic [3:0]  round_q, round_d;
    logic [15:0] best_q, best_d;
    logic [15:0] t_q, t_d;
    logic [2:0]  dly_q, dly_d;
    logic [13:0] ms_q, ms_d;
    logic [15:0] hex_q, hex_d;
    logic        run_q, run_d;
    logic        cclr_q, cclr_d;
    logic        done_q, done_d;

    logic [15:0] live;
    logic        tick;
    logic        unused_rnd;

    assign live       = {d3, d2, d1, d0};
    assign unused_rnd = rnd[3];

    // Prescaler only runs inside WAIT, so it restarts from zero on every entry.
    ms_tick_gen #(
        .CLK_PER_MS(CLK_PER_MS)
    ) u_tick (
        .clk  (clk),
        .clear(clear || (state_q != StWait)),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        best_d  = best_q;
        t_d     = t_q;
        dly_d   = dly_q;
        ms_d    = ms_q;
        unique case (state_q)
            StIdle, StSummary: begin
                if (start) begin
                    state_d = StWait;
                    round_d = '0;
                    best_d  = SCORE_FOUL;
                    dly_d   = rnd[2:0];
                    ms_d    = '0;
                end
            end
            StWait: begin
                if (stop) begin
                    state_d = StFoul;
                end else if (tick) begin
                    if (ms_q == wait_ms(dly_q) - 14'd1) begin
                        state_d = StTiming;
                    end else begin
                        ms_d = ms_q + 14'd1;
                    end
                end
            end
            StTiming: begin
                // A timeout coinciding with stop still captures 1000, so one path covers both.
                if (stop || (live == T_TIMEOUT)) begin
                    t_d     = live;
                    state_d = StResult;
                    if (live < best_q) begin
                        best_d = live;
                    end
                end
            end
            StResult, StFoul: begin
                if (start) begin
                    if (round_q == 4'(NUM_ROUNDS - 1)) begin
                        state_d = StSummary;
                    end else begin
                        state_d = StWait;
                        round_d = round_q + 4'd1;
                        dly_d   = rnd[2:0];
                        ms_d    = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        run_d  = (state_d == StTiming);
        cclr_d = (state_d == StWait) && (state_q != StWait);
        done_d = (state_d == StSummary) && (state_q != StSummary);
        unique case (state_d)
            StWait:    hex_d = DISP_WAIT;
            StTiming:  hex_d = live;
            StResult:  hex_d = t_d;
            StFoul:    hex_d = DISP_FOUL;
            StSummary: hex_d = best_d;
            default:   hex_d = DISP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= StIdle;
            round_q <= '0;
            best_q  <= SCORE_FOUL;
            t_q     <= '0;
            dly_q   <= '0;
            ms_q    <= '0;
            hex_q   <= '0;
            run_q   <= 1'b0;
            cclr_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            best_q  <= best_d;
            t_q     <= t_d;
            dly_q   <= dly_d;
            ms_q    <= ms_d;
            hex_q   <= hex_d;
            run_q   <= run_d;
            cclr_q  <= cclr_d;
            done_q  <= done_d;
        end
    end

    assign count_start  = run_q;
    assign led          = run_q;
    assign count_clear  = cclr_q;
    assign session_done = done_q;
    assign round_idx    = round_q;
    assign {hex3, hex2, hex1, hex0} = hex_q;

endmodule
